// File: rtl/exec_ctrl_pkg.sv
// Shared types and constants for the execute-stage controller.
package exec_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } exec_state_t;

    localparam int MAX_WAIT_DEFAULT = 64;

endpackage

// File: rtl/exec_ctrl_wait.sv
// WAIT watchdog: counts cycles spent waiting on the FPU and flags expiry.
module wait_timer
    import exec_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    // Expiry fires on the cycle whose increment would bring the count to MAX_WAIT-1.
    localparam logic [7:0] LAST = 8'(MAX_WAIT - 2);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/exec_ctrl.sv
// Execute-stage controller: issues ALU results directly, sequences multi-cycle FPU ops.
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_multi,
    input  logic [31:0] alu_result,
    output logic        unit_start,
    output logic        unit_abort,
    input  logic        unit_fin,
    input  logic [31:0] unit_result,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        timeout,
    output logic [15:0] stall_count
);

    exec_state_t state;
    logic        accept;
    logic        timer_clear;
    logic        timer_enable;
    logic        expire;

    assign in_ready     = (state == IDLE) && (!out_valid || out_ready) && !flush;
    assign accept       = in_valid && in_ready;
    assign unit_start   = !rst && accept && in_multi;
    assign timer_clear  = (state == IDLE) || flush;
    assign timer_enable = (state == WAIT) && !unit_fin && !flush;
    assign unit_abort   = !rst && (state == WAIT) && (flush || expire);

    wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_result  <= '0;
            timeout     <= 1'b0;
            stall_count <= '0;
        end else begin
            if (in_valid && !in_ready && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
            if (flush) begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
                case (state)
                    IDLE: begin
                        if (accept) begin
                            if (in_multi) begin
                                state <= WAIT;
                            end else begin
                                out_valid  <= 1'b1;
                                out_result <= alu_result;
                            end
                        end
                    end
                    WAIT: begin
                        // A completion arriving on the expiry cycle still wins.
                        if (unit_fin) begin
                            out_valid  <= 1'b1;
                            out_result <= unit_result;
                            state      <= IDLE;
                        end else if (expire) begin
                            timeout <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: directed scenarios plus a randomized run against a reference model.
module tb_exec_ctrl;

    localparam int MW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_multi;
    logic [31:0] alu_result;
    logic        unit_start;
    logic        unit_abort;
    logic        unit_fin;
    logic [31:0] unit_result;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        timeout;
    logic [15:0] stall_count;

    int total = 0;
    int bad   = 0;

    exec_ctrl #(.MAX_WAIT(MW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_multi    (in_multi),
        .alu_result  (alu_result),
        .unit_start  (unit_start),
        .unit_abort  (unit_abort),
        .unit_fin    (unit_fin),
        .unit_result (unit_result),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .timeout     (timeout),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        in_multi    = 1'b0;
        alu_result  = '0;
        unit_fin    = 1'b0;
        unit_result = '0;
        flush       = 1'b0;
        out_ready   = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        in_valid = 1'b1;
        in_multi = 1'b1;
        unit_fin = 1'b1;
        #1;
        total++; if (unit_start !== 1'b0) begin bad++; $display("FAIL rst_start: got %b want 0", unit_start); end
        total++; if (unit_abort !== 1'b0) begin bad++; $display("FAIL rst_abort: got %b want 0", unit_abort); end
        tick();
        tick();
        idle_inputs();
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_ov: got %b want 0", out_valid); end
        total++; if (out_result !== 32'h0) begin bad++; $display("FAIL rst_res: got %h want 0", out_result); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_to: got %b want 0", timeout); end
        total++; if (stall_count !== 16'h0) begin bad++; $display("FAIL rst_stall: got %0d want 0", stall_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_alu();
        do_reset();
        in_valid = 1'b1;
        alu_result = 32'h5;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL alu_ready: got %b want 1", in_ready); end
        total++; if (unit_start !== 1'b0) begin bad++; $display("FAIL alu_start: got %b want 0", unit_start); end
        tick();
        alu_result = 32'h7;
        #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL alu_ov: got %b want 1", out_valid); end
        total++; if (out_result !== 32'h5) begin bad++; $display("FAIL alu_res: got %h want 5", out_result); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL alu_b2b_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        total++; if (out_result !== 32'h7) begin bad++; $display("FAIL alu_b2b_res: got %h want 7", out_result); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL alu_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_fpu();
        do_reset();
        in_valid = 1'b1;
        in_multi = 1'b1;
        #1;
        total++; if (unit_start !== 1'b1) begin bad++; $display("FAIL fpu_start: got %b want 1", unit_start); end
        tick();
        in_valid = 1'b0;
        in_multi = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) begin
                unit_fin = 1'b1;
                unit_result = 32'h3F800000;
            end
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fpu_ready_c%0d: got %b want 0", k, in_ready); end
            total++; if (unit_start !== 1'b0) begin bad++; $display("FAIL fpu_start_once_c%0d: got %b want 0", k, unit_start); end
            tick();
        end
        unit_fin = 1'b0;
        #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fpu_ov: got %b want 1", out_valid); end
        total++; if (out_result !== 32'h3F800000) begin bad++; $display("FAIL fpu_res: got %h want 3f800000", out_result); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fpu_ready_after: got %b want 1", in_ready); end
    endtask

    task automatic test_hold();
        do_reset();
        in_valid = 1'b1;
        alu_result = 32'hA5A5;
        tick();
        out_ready = 1'b0;
        alu_result = 32'h1234;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_ready_%0d: got %b want 0", k, in_ready); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_ov_%0d: got %b want 1", k, out_valid); end
            total++; if (out_result !== 32'hA5A5) begin bad++; $display("FAIL hold_res_%0d: got %h want a5a5", k, out_result); end
            tick();
        end
        in_valid = 1'b0;
        #1;
        total++; if (stall_count !== 16'd4) begin bad++; $display("FAIL hold_stall: got %0d want 4", stall_count); end
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_release: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1;
        in_multi = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        unit_fin = 1'b1;
        unit_result = 32'hDEAD;
        #1;
        total++; if (unit_abort !== 1'b1) begin bad++; $display("FAIL flush_abort: got %b want 1", unit_abort); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        tick();
        flush = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_ov: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_idle: got %b want 1", in_ready); end
        total++; if (unit_abort !== 1'b0) begin bad++; $display("FAIL flush_abort_idle: got %b want 0", unit_abort); end
        tick();
        unit_fin = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_stray_fin: got %b want 0", out_valid); end
    endtask

    task automatic test_timeout();
        do_reset();
        in_valid = 1'b1;
        in_multi = 1'b1;
        tick();
        in_valid = 1'b0;
        in_multi = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            #1;
            total++; if (unit_abort !== (k == 7)) begin bad++; $display("FAIL to_abort_c%0d: got %b want %b", k, unit_abort, k == 7); end
            total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_early_c%0d: got %b want 0", k, timeout); end
            tick();
        end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_set: got %b want 1", timeout); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL to_ov: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL to_idle: got %b want 1", in_ready); end
        in_valid = 1'b1;
        alu_result = 32'h9;
        tick();
        in_valid = 1'b0;
        tick();
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", timeout); end
        do_reset();
        #1;
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_cleared: got %b want 0", timeout); end
    endtask

    task automatic test_rst_wait();
        do_reset();
        in_valid = 1'b1;
        alu_result = 32'h77;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rw_held_ov: got %b want 0", out_valid); end
        total++; if (out_result !== 32'h0) begin bad++; $display("FAIL rw_held_res: got %h want 0", out_result); end
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_multi = 1'b1;
        tick();
        in_valid = 1'b0;
        in_multi = 1'b0;
        rst = 1'b1;
        unit_fin = 1'b1;
        unit_result = 32'hBEEF;
        #1;
        total++; if (unit_abort !== 1'b0) begin bad++; $display("FAIL rw_abort: got %b want 0", unit_abort); end
        tick();
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rw_ov: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rw_idle: got %b want 1", in_ready); end
        tick();
        unit_fin = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rw_late_fin: got %b want 0", out_valid); end
        total++; if (out_result !== 32'h0) begin bad++; $display("FAIL rw_late_res: got %h want 0", out_result); end
    endtask

    // Reference model: a pending FPU job with elapsed-cycle count, a one-entry result slot.
    task automatic test_random();
        bit          busy = 0;
        int          waited = 0;
        bit          slot_full = 0;
        logic [31:0] slot = '0;
        bit          to_flag = 0;
        int          stalls = 0;
        bit          e_ready, e_start, e_abort, acc;
        do_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            rst         = ($urandom_range(0, 79) == 0);
            flush       = ($urandom_range(0, 15) == 0);
            in_valid    = $urandom_range(0, 1);
            in_multi    = ($urandom_range(0, 2) == 0);
            alu_result  = $urandom;
            unit_fin    = ($urandom_range(0, 7) == 0);
            unit_result = $urandom;
            out_ready   = ($urandom_range(0, 3) != 0);
            #1;
            e_ready = !busy && (!slot_full || out_ready) && !flush;
            acc     = in_valid && e_ready;
            e_start = !rst && acc && in_multi;
            e_abort = !rst && busy && (flush || (!unit_fin && waited + 1 == MW - 1));
            total++; if (in_ready !== e_ready) begin bad++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, in_ready, e_ready); end
            total++; if (unit_start !== e_start) begin bad++; $display("FAIL rnd_start@%0d: got %b want %b", cyc, unit_start, e_start); end
            total++; if (unit_abort !== e_abort) begin bad++; $display("FAIL rnd_abort@%0d: got %b want %b", cyc, unit_abort, e_abort); end
            if (rst) begin
                busy = 0; waited = 0; slot_full = 0; slot = '0; to_flag = 0; stalls = 0;
            end else begin
                if (in_valid && !e_ready && stalls < 65535) stalls++;
                if (flush) begin
                    busy = 0;
                    slot_full = 0;
                end else begin
                    if (slot_full && out_ready) slot_full = 0;
                    if (!busy) begin
                        if (acc && in_multi) begin
                            busy = 1;
                            waited = 0;
                        end else if (acc) begin
                            slot_full = 1;
                            slot = alu_result;
                        end
                    end else if (unit_fin) begin
                        busy = 0;
                        slot_full = 1;
                        slot = unit_result;
                    end else if (e_abort) begin
                        busy = 0;
                        to_flag = 1;
                    end else begin
                        waited++;
                    end
                end
            end
            tick();
            total++; if (out_valid !== slot_full) begin bad++; $display("FAIL rnd_ov@%0d: got %b want %b", cyc, out_valid, slot_full); end
            total++; if (out_result !== slot) begin bad++; $display("FAIL rnd_res@%0d: got %h want %h", cyc, out_result, slot); end
            total++; if (timeout !== to_flag) begin bad++; $display("FAIL rnd_to@%0d: got %b want %b", cyc, timeout, to_flag); end
            total++; if (stall_count !== 16'(stalls)) begin bad++; $display("FAIL rnd_stall@%0d: got %0d want %0d", cyc, stall_count, stalls); end
        end
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_alu();
        test_fpu();
        test_hold();
        test_flush();
        test_timeout();
        test_rst_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
